// File: rtl/instr_asm_pkg.sv
// Shared symbol codes, FSM state type and parity helper for the instruction assembler.
package instr_asm_pkg;

    localparam logic [1:0] SYM_BIT0   = 2'b00;
    localparam logic [1:0] SYM_BIT1   = 2'b01;
    localparam logic [1:0] SYM_RESUME = 2'b10;
    localparam logic [1:0] SYM_EOP    = 2'b11;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_par(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/instr_assembler_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is forced to zero while empty.
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_assembler.sv
// Assembles MSB-first bit symbols into instructions, buffers them, releases on end-of-program.
// Optional trailing even-parity symbol per instruction: define INSTR_PARITY_EN.
module instr_assembler
    import instr_asm_pkg::*;
#(
    parameter int INSTR_W = 13,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sym_valid,
    input  logic [1:0]         sym,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               start,
    output logic [CNT_W-1:0]   instr_count,
    output logic               overflow,
    output logic               parity_err
);
`ifdef INSTR_PARITY_EN
    localparam int BITS = INSTR_W + 1;
`else
    localparam int BITS = INSTR_W;
`endif
    localparam int PTR_W = $clog2(BITS + 1);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] sr;
    logic [PTR_W-1:0]   ptr;
    logic [INSTR_W-1:0] word;
    logic               is_bit, last_bit, par_ok, resume, push, pop, flush;
    logic               full, empty;

    assign is_bit   = sym_valid && !sym[1];
    assign resume   = sym_valid && (sym == SYM_RESUME);
    assign last_bit = (state_q == LOAD) && is_bit && (ptr == PTR_W'(BITS - 1));

`ifdef INSTR_PARITY_EN
    // The final symbol is the parity bit; the data bits are already in sr.
    assign word   = sr;
    assign par_ok = (even_par(32'(sr)) == sym[0]);
`else
    assign word   = {sr[INSTR_W-2:0], sym[0]};
    assign par_ok = 1'b1;
`endif

    assign push      = last_bit && par_ok && !full;
    assign flush     = (state_q == RUN) && resume;
    assign out_valid = (state_q == RUN) && !empty;
    assign pop       = out_valid && out_ready;
    assign start     = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (sym_valid && sym == SYM_EOP) state_d = RUN;
            RUN:  if (resume) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= '0;
            ptr         <= '0;
            instr_count <= '0;
            overflow    <= 1'b0;
        end else if (flush) begin
            ptr         <= '0;
            instr_count <= '0;
            overflow    <= 1'b0;
        end else if (state_q == LOAD && sym_valid) begin
            if (is_bit) begin
                sr  <= {sr[INSTR_W-2:0], sym[0]};
                ptr <= last_bit ? '0 : ptr + 1'b1;
                if (push && instr_count != '1)
                    instr_count <= instr_count + 1'b1;
                if (last_bit && par_ok && full)
                    overflow <= 1'b1;
            end else if (sym == SYM_EOP) begin
                ptr <= '0;
            end
        end
    end

`ifdef INSTR_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || flush)
            parity_err <= 1'b0;
        else if (last_bit && !par_ok)
            parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (word),
        .dout  (out_instr),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler (INSTR_W=13, DEPTH=4); honours INSTR_PARITY_EN.
module tb_instr_assembler;
    localparam int INSTR_W = 13;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sym_valid = 1'b0;
    logic [1:0]         sym = 2'b00;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic               start;
    logic [CNT_W-1:0]   instr_count;
    logic               overflow;
    logic               parity_err;

    int total = 0;
    int bad   = 0;
    logic [INSTR_W-1:0] exp_q[$];
    int m_cnt = 0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    instr_assembler #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .start       (start),
        .instr_count (instr_count),
        .overflow    (overflow),
        .parity_err  (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1, so DUT sees stable inputs.
    task automatic send_sym(input logic [1:0] s);
        sym_valid = 1'b1;
        sym = s;
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [INSTR_W-1:0] w);
        for (int i = INSTR_W - 1; i >= 0; i--)
            send_sym({1'b0, w[i]});
    endtask

    task automatic send_instr(input logic [INSTR_W-1:0] w);
        send_raw(w);
`ifdef INSTR_PARITY_EN
        send_sym({1'b0, ^w});
`endif
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic resume();
        send_sym(2'b10);
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic drain(input int expn);
        int n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!out_valid) break;
            if (exp_q.size() == 0) chk("spurious_pop", 32'(out_instr), 32'hdead);
            else chk("pop_data", 32'(out_instr), 32'(exp_q.pop_front()));
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_n", n, expn);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        @(negedge clk);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_instr"}, 32'(out_instr), 0);
        chk({tag, "_count"}, 32'(instr_count), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_perr"}, 32'(parity_err), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("rst");

        // Two instructions, released and popped back-to-back.
        send_instr(13'h1A5A);
        send_instr(13'h0003);
        @(negedge clk);
        chk("t1_count", 32'(instr_count), 2);
        chk("t1_start_pre", 32'(start), 0);
        @(posedge clk); #1;
        send_sym(2'b11);
        @(negedge clk);
        chk("t1_start", 32'(start), 1);
        chk("t1_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        drain(2);
        chk("t1_count_run", 32'(instr_count), 2);

        // Overflow: five loaded into four entries.
        resume();
        for (int i = 0; i < 5; i++) send_instr(INSTR_W'($urandom));
        @(negedge clk);
        chk("t2_ovf", 32'(overflow), 32'(m_ovf));
        chk("t2_count", 32'(instr_count), m_cnt);
        @(posedge clk); #1;
        send_sym(2'b11);
        drain(4);
        chk("t2_ovf_run", 32'(overflow), 1);
        resume();
        @(negedge clk);
        chk("t2_ovf_clr", 32'(overflow), 0);
        @(posedge clk); #1;

        // Partial instruction discarded by end-of-program.
        for (int i = 0; i < 7; i++) send_sym(2'b01);
        send_sym(2'b11);
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 0);
        chk("t3_start", 32'(start), 1);
        chk("t3_count", 32'(instr_count), 0);
        @(posedge clk); #1;

        // Resume while holding three, with a pop requested in the resume cycle.
        resume();
        for (int i = 0; i < 3; i++) send_instr(INSTR_W'(13'h0100 + i));
        send_sym(2'b11);
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b1;
        resume();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_start", 32'(start), 0);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_count", 32'(instr_count), 0);
        chk("t4_ovf", 32'(overflow), 0);
        @(posedge clk); #1;
        send_instr(13'h1FFF);
        send_sym(2'b11);
        drain(1);

        // Reset with two buffered plus eight bits in flight.
        resume();
        send_instr(13'h0AAA);
        send_instr(13'h1555);
        for (int i = 0; i < 8; i++) send_sym(2'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        chk_reset("t5");
        // Bits in flight before reset must not leak into the next word.
        send_instr(13'h0005);
        send_sym(2'b11);
        drain(1);

`ifdef INSTR_PARITY_EN
        resume();
        send_raw(13'h0001);
        send_sym(2'b00);
        @(negedge clk);
        chk("t6_perr", 32'(parity_err), 1);
        chk("t6_count", 32'(instr_count), 0);
        @(posedge clk); #1;
        send_instr(13'h0001);
        @(negedge clk);
        chk("t6_count_ok", 32'(instr_count), 1);
        @(posedge clk); #1;
        send_sym(2'b11);
        drain(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Parametrised successor to the single-instruction UART loader. It consumes 2-bit symbols from the UART receive path (bit-0, bit-1, end-of-program, resume) and assembles INSTR_W-bit instructions MSB-first. Completed instructions are buffered in a DEPTH-entry FIFO. On end-of-program, the buffered program is released to the flow-control sequencer over a valid/ready handshake. It sits between the UART receiver and the valve/pump sequencer.

## Interface
- INSTR_W, 13, instruction width in bits (2..32)
- DEPTH, 16, FIFO entries (power of two, 2..256)
- CNT_W, 8, width of instruction counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sym_valid  in  1  one-cycle strobe, sym is valid
- sym  in  2  symbol: 00 bit 0, 01 bit 1, 11 end-of-program, 10 resume
- out_valid  out  1  head instruction available (RUN state only)
- out_ready  in  1  sequencer accepts head instruction
- out_instr  out  INSTR_W  FIFO head instruction
- start  out  1  high while in RUN (program released)
- instr_count  out  CNT_W  instructions accepted into FIFO since last load, saturating
- overflow  out  1  sticky: instruction dropped, FIFO full
- parity_err  out  1  sticky: parity mismatch (tied 0 without INSTR_PARITY_EN)

## Operation
- States: LOAD (reset state), RUN.
- LOAD, sym 00/01: sym[0] is shifted into the shift register, MSB first, and the bit pointer is incremented.
- LOAD, INSTR_W-th bit: the instruction is complete.
  - FIFO not full: push, and instr_count += 1 (saturates at all-ones).
  - FIFO full: drop the instruction and set overflow.
  - In both cases the pointer returns to 0.
- LOAD, sym 11: a partial instruction is discarded and the pointer cleared. Go to RUN with start=1.
- LOAD, sym 10: ignored.
- RUN: out_valid = FIFO not empty. A pop occurs when out_valid && out_ready. Bit symbols and 11 are ignored.
- RUN, sym 10: go to LOAD, start=0.
  - FIFO flushed, instr_count=0, pointer=0.
  - overflow and parity_err cleared.
- out_instr is the FIFO head. Its value is don't-care when out_valid=0.
- Push and pop never coincide: push happens only in LOAD, pop only in RUN.
- sym_valid=0: no state change other than pops.

## Timing
- Reset values: start=0, out_valid=0, out_instr=0, instr_count=0, overflow=0, parity_err=0; state LOAD, FIFO empty, pointer 0.
- rst mid-load or mid-drain: immediate return to reset values. Partial and buffered data are lost.
- Final bit sampled at edge N: FIFO entry and instr_count are updated at edge N.
- End-of-program sampled at edge M: start and out_valid (if FIFO non-empty) are high after edge M.
- Pop at edge K: the next head is on out_instr after edge K, so back-to-back pops give one instruction per cycle.
- Resume at edge R: out_valid=0 after edge R. A pop requested in the same cycle is discarded with the flush.
- FIFO occupancy 0..DEPTH; pointers wrap modulo DEPTH with an extra wrap bit for full/empty.

## Configuration
- INSTR_PARITY_EN defined:
  - Each instruction is followed by one extra bit symbol carrying even parity over the INSTR_W bits.
  - On mismatch the instruction is dropped (not pushed, not counted) and parity_err is set.
  - The pointer counts to INSTR_W+1.
- INSTR_PARITY_EN undefined: no parity symbol, and parity_err is constant 0.

## Structure
- Package instr_asm_pkg:
  - symbol codes SYM_BIT0=2'b00, SYM_BIT1=2'b01, SYM_RESUME=2'b10, SYM_EOP=2'b11
  - state typedef (LOAD, RUN)
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/flush, full/empty, head output), instantiated once.
- Shift register, bit pointer, FSM, counter and sticky flags live in instr_assembler.

## Test plan
- INSTR_W=13: send 26 bit symbols encoding 0x1A5A then 0x0003, then 11, out_ready=1 → out_instr 0x1A5A then 0x0003 on consecutive cycles; instr_count=2; start=1.
- DEPTH=4: load 5 instructions, then 11 → overflow=1, instr_count=4, only the first 4 are popped.
- Send 7 bit symbols, then 11 → partial discarded, out_valid=0, start=1, instr_count=0.
- In RUN with 3 buffered and out_ready=0, send 10 → start=0, FIFO empty, instr_count=0, flags cleared; a new load then works normally.
- Assert rst while 8 bits are in the shift register and 2 entries are in the FIFO → all outputs at reset values the next cycle.
- INSTR_PARITY_EN: instruction 0x0001 with parity bit 0 (wrong; 1 is required) → dropped, parity_err=1; correct parity → pushed.
